// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display stage: glyph constants (bit 0 = a)
// and the blink FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    SHOW = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2
  } blink_state_t;

endpackage

// File: rtl/seg7_display_driver_if.sv
// Bundle between the upstream digit counter (master) and the display driver (slave).
interface seg7_display_driver_if #(
  parameter int PWM_BITS = 3
);

  logic [3:0]          digit;
  logic                tick;
  logic [PWM_BITS-1:0] brightness;
  logic [6:0]          segments;
  logic                dp;
  logic                blinking;

  modport master (
    output digit, tick, brightness,
    input  segments, dp, blinking
  );

  modport slave (
    input  digit, tick, brightness,
    output segments, dp, blinking
  );

endinterface

// File: rtl/seg7_glyph.sv
// Combinational 4-bit value to 7-segment glyph decoder.
// Define SEG_HEX_EN to show A..F for values 10..15; otherwise they are blank.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (value)
      4'd0:  glyph = SEG_0;
      4'd1:  glyph = SEG_1;
      4'd2:  glyph = SEG_2;
      4'd3:  glyph = SEG_3;
      4'd4:  glyph = SEG_4;
      4'd5:  glyph = SEG_5;
      4'd6:  glyph = SEG_6;
      4'd7:  glyph = SEG_7;
      4'd8:  glyph = SEG_8;
      4'd9:  glyph = SEG_9;
`ifdef SEG_HEX_EN
      4'd10: glyph = SEG_A;
      4'd11: glyph = SEG_B;
      4'd12: glyph = SEG_C;
      4'd13: glyph = SEG_D;
      4'd14: glyph = SEG_E;
      4'd15: glyph = SEG_F;
`else
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: glyph = SEG_BLANK;
`endif
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_driver.sv
// Registered 7-segment output stage: digit latch, brightness PWM, wrap-triggered
// blink FSM and heartbeat decimal point. Hex glyphs selectable with SEG_HEX_EN.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter logic [3:0]  MAX_DIGIT    = 4'd8,
  parameter int          PWM_BITS     = 3,
  parameter logic [23:0] BLINK_PERIOD = 24'd5_000_000,
  parameter int          BLINK_COUNT  = 3
)(
  input logic                   clk,
  input logic                   reset,
  seg7_display_driver_if.slave  bus
);

  localparam int FLASH_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  logic [3:0]          digit_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  blink_state_t        state, state_nxt;
  logic [23:0]         phase, phase_nxt;
  logic [FLASH_W-1:0]  flash, flash_nxt;
  logic                heartbeat;
  logic [6:0]          segments_q;
  logic                dp_q;
  logic [6:0]          glyph;
  logic                pwm_en;
  logic                wrap;

  seg7_glyph u_glyph (
    .value (digit_q),
    .glyph (glyph)
  );

  assign wrap   = (digit_q == MAX_DIGIT) && (bus.digit == 4'd0);
  assign pwm_en = (bright_q == '1) || (pwm_cnt < bright_q);

  // A wrap always (re)starts the sequence; ON ends after BLINK_COUNT flashes.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    flash_nxt = flash;
    if (wrap) begin
      state_nxt = OFF;
      phase_nxt = 24'd0;
      flash_nxt = '0;
    end else begin
      case (state)
        SHOW: ;
        OFF: begin
          if (phase == BLINK_PERIOD - 24'd1) begin
            state_nxt = ON;
            phase_nxt = 24'd0;
          end else begin
            phase_nxt = phase + 24'd1;
          end
        end
        ON: begin
          if (phase == BLINK_PERIOD - 24'd1) begin
            phase_nxt = 24'd0;
            if (flash == FLASH_W'(BLINK_COUNT - 1)) begin
              state_nxt = SHOW;
              flash_nxt = '0;
            end else begin
              state_nxt = OFF;
              flash_nxt = flash + FLASH_W'(1);
            end
          end else begin
            phase_nxt = phase + 24'd1;
          end
        end
        default: begin
          state_nxt = SHOW;
          phase_nxt = 24'd0;
          flash_nxt = '0;
        end
      endcase
    end
  end

  // Output gating uses the next FSM state so blanking starts the cycle after a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q    <= 4'd0;
      pwm_cnt    <= '0;
      bright_q   <= '0;
      state      <= SHOW;
      phase      <= 24'd0;
      flash      <= '0;
      heartbeat  <= 1'b0;
      segments_q <= SEG_BLANK;
      dp_q       <= 1'b0;
    end else begin
      digit_q   <= bus.digit;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (pwm_cnt == '0)
        bright_q <= bus.brightness;
      state     <= state_nxt;
      phase     <= phase_nxt;
      flash     <= flash_nxt;
      heartbeat <= heartbeat ^ bus.tick;
      dp_q      <= (heartbeat ^ bus.tick) & pwm_en;
      if (state_nxt == OFF)
        segments_q <= SEG_BLANK;
      else
        segments_q <= glyph & {7{pwm_en}};
    end
  end

  assign bus.segments = segments_q;
  assign bus.dp       = dp_q;
  assign bus.blinking = (state != SHOW);

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed self-checking bench for seg7_display_driver (BLINK_PERIOD=4, BLINK_COUNT=2).
module tb_seg7_display_driver;

  localparam int PWM_BITS = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lit_cnt;
  logic [6:0] lit_val;
  logic [6:0] exp_seg;
  logic [6:0] exp_hex;

  seg7_display_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

  seg7_display_driver #(
    .MAX_DIGIT    (4'd8),
    .PWM_BITS     (PWM_BITS),
    .BLINK_PERIOD (24'd4),
    .BLINK_COUNT  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] d, input logic t, input logic [2:0] b);
    bus.digit      = d;
    bus.tick       = t;
    bus.brightness = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Counts lit cycles over one 8-cycle PWM period, remembering the lit glyph.
  task automatic pwmWindow();
    lit_cnt = 0;
    lit_val = 7'h00;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.segments != 7'h00) begin
        lit_cnt++;
        lit_val = bus.segments;
      end
    end
  endtask

  initial begin
`ifdef SEG_HEX_EN
    exp_hex = 7'h39;
`else
    exp_hex = 7'h00;
`endif
    $display("[TB] start");

    applyStimulus(4'd5, 1'b0, 3'd7);
    reset = 1'b1;
    step(2);
    checkOutput("reset_seg",   {1'b0, bus.segments}, 8'h00);
    checkOutput("reset_dp",    {7'b0, bus.dp},       8'h00);
    checkOutput("reset_blink", {7'b0, bus.blinking}, 8'h00);
    reset = 1'b0;
    step(1);
    checkOutput("latency1_seg", {1'b0, bus.segments}, 8'h00);
    step(1);
    checkOutput("latency2_seg", {1'b0, bus.segments}, 8'h6D);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput("steady5_seg", {1'b0, bus.segments}, 8'h6D);
    end

    applyStimulus(4'd1, 1'b0, 3'd3);
    step(16);
    pwmWindow();
    checkOutput("pwm3_count_a", 8'(lit_cnt), 8'd3);
    checkOutput("pwm3_glyph",   {1'b0, lit_val}, 8'h06);
    pwmWindow();
    checkOutput("pwm3_count_b", 8'(lit_cnt), 8'd3);
    applyStimulus(4'd1, 1'b0, 3'd0);
    step(16);
    pwmWindow();
    checkOutput("pwm0_count", 8'(lit_cnt), 8'd0);

    applyStimulus(4'd8, 1'b0, 3'd7);
    step(12);
    checkOutput("prewrap_seg",   {1'b0, bus.segments}, 8'h7F);
    checkOutput("prewrap_blink", {7'b0, bus.blinking}, 8'h00);
    applyStimulus(4'd0, 1'b0, 3'd7);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp_seg = ((k >= 1 && k <= 4) || (k >= 9 && k <= 12)) ? 7'h00 : 7'h3F;
      checkOutput("blink_state", {7'b0, bus.blinking}, 8'h01);
      checkOutput("blink_seg",   {1'b0, bus.segments}, {1'b0, exp_seg});
    end
    step(1);
    checkOutput("blink_end_state", {7'b0, bus.blinking}, 8'h00);
    checkOutput("blink_end_seg",   {1'b0, bus.segments}, 8'h3F);

    applyStimulus(4'd8, 1'b0, 3'd7);
    step(3);
    applyStimulus(4'd0, 1'b0, 3'd7);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checkOutput("restart_first_off", {1'b0, bus.segments}, 8'h00);
    end
    applyStimulus(4'd8, 1'b0, 3'd7);
    step(1);
    checkOutput("restart_on_seg",   {1'b0, bus.segments}, 8'h3F);
    checkOutput("restart_on_state", {7'b0, bus.blinking}, 8'h01);
    applyStimulus(4'd0, 1'b0, 3'd7);
    for (int k = 6; k <= 21; k++) begin
      step(1);
      exp_seg = (((k - 6) % 8) < 4) ? 7'h00 : 7'h3F;
      checkOutput("restart_state", {7'b0, bus.blinking}, 8'h01);
      checkOutput("restart_seg",   {1'b0, bus.segments}, {1'b0, exp_seg});
    end
    step(1);
    checkOutput("restart_end_state", {7'b0, bus.blinking}, 8'h00);

    applyStimulus(4'd8, 1'b0, 3'd7);
    step(3);
    applyStimulus(4'd3, 1'b0, 3'd7);
    step(2);
    checkOutput("skip_8to3_state", {7'b0, bus.blinking}, 8'h00);
    checkOutput("skip_8to3_seg",   {1'b0, bus.segments}, 8'h4F);
    applyStimulus(4'd7, 1'b0, 3'd7);
    step(3);
    applyStimulus(4'd0, 1'b0, 3'd7);
    step(2);
    checkOutput("skip_7to0_state", {7'b0, bus.blinking}, 8'h00);
    checkOutput("skip_7to0_seg",   {1'b0, bus.segments}, 8'h3F);

    applyStimulus(4'd12, 1'b0, 3'd7);
    step(3);
    checkOutput("hex12_seg", {1'b0, bus.segments}, {1'b0, exp_hex});

    checkOutput("dp_idle", {7'b0, bus.dp}, 8'h00);
    applyStimulus(4'd12, 1'b1, 3'd7);
    step(1);
    applyStimulus(4'd12, 1'b0, 3'd7);
    checkOutput("dp_tick1", {7'b0, bus.dp}, 8'h01);
    step(9);
    checkOutput("dp_hold", {7'b0, bus.dp}, 8'h01);
    applyStimulus(4'd12, 1'b1, 3'd7);
    step(1);
    applyStimulus(4'd12, 1'b0, 3'd7);
    checkOutput("dp_tick2", {7'b0, bus.dp}, 8'h00);
    applyStimulus(4'd12, 1'b1, 3'd7);
    step(1);
    applyStimulus(4'd8, 1'b0, 3'd7);
    checkOutput("dp_tick3", {7'b0, bus.dp}, 8'h01);

    step(3);
    applyStimulus(4'd0, 1'b1, 3'd7);
    step(1);
    applyStimulus(4'd0, 1'b0, 3'd7);
    checkOutput("tickwrap_state", {7'b0, bus.blinking}, 8'h01);
    checkOutput("tickwrap_dp",    {7'b0, bus.dp},       8'h00);
    checkOutput("tickwrap_seg",   {1'b0, bus.segments}, 8'h00);
    step(2);
    checkOutput("midblink_state", {7'b0, bus.blinking}, 8'h01);

    applyStimulus(4'd0, 1'b1, 3'd7);
    step(1);
    applyStimulus(4'd0, 1'b0, 3'd7);
    checkOutput("midblink_dp", {7'b0, bus.dp}, 8'h01);
    reset = 1'b1;
    step(1);
    checkOutput("midreset_state", {7'b0, bus.blinking}, 8'h00);
    checkOutput("midreset_dp",    {7'b0, bus.dp},       8'h00);
    checkOutput("midreset_seg",   {1'b0, bus.segments}, 8'h00);
    reset = 1'b0;
    step(1);
    checkOutput("postreset_state", {7'b0, bus.blinking}, 8'h00);
    step(2);
    checkOutput("postreset_seg", {1'b0, bus.segments}, 8'h3F);
    applyStimulus(4'd0, 1'b1, 3'd7);
    step(1);
    applyStimulus(4'd0, 1'b0, 3'd7);
    checkOutput("postreset_dp", {7'b0, bus.dp}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
